// File: rtl/qtpa_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package qtpa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam int FETCH_DEPTH      = 256;
  localparam int FETCH_MAX_CYCLES = 1000;

endpackage

// File: rtl/fetch_imem.sv
// Instruction store: one write port, one combinational read port, no reset.
// Read data follows rd_addr in the same cycle; writes land on the rising edge.
module fetch_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Loads a program in IDLE, then streams it cyclically to the core with zero-bubble
// valid/ready handshakes; word and pc hold while the core stalls.
module instr_fetch_unit
  import qtpa_pkg::*;
#(
  parameter int DEPTH      = FETCH_DEPTH,
  parameter int MAX_CYCLES = FETCH_MAX_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_full,
  input  logic        start,
  input  logic        instr_ready,
  input  logic        illegal,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [7:0]  pc,
  output logic [8:0]  instr_count,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        halted_illegal
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic         vld_q, vld_d;
  logic [7:0]   pc_q, pc_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [31:0]  cyc_q, cyc_d;

  logic         wr_en;
  logic [7:0]   pc_inc;
  logic [7:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         hs;
  logic         can_start;
  logic         full;

  fetch_imem #(.DEPTH(DEPTH), .AW(AW)) u_imem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_data (ld_data),
    .rd_addr (rd_addr[AW-1:0]),
    .rd_data (rd_data)
  );

  assign full      = (cnt_q == 9'(DEPTH));
  assign hs        = (state_q == S_RUN) && vld_q && instr_ready;
  assign can_start = start && (cnt_q != 9'd0);
  assign pc_inc    = (({1'b0, pc_q} + 9'd1) == cnt_q) ? 8'd0 : pc_q + 8'd1;
  // Outside RUN the only read that matters is word 0 for a (re)start.
  assign rd_addr   = (state_q == S_RUN) ? pc_inc : 8'd0;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_HALT: begin
        if (can_start) begin
          state_d = S_RUN;
          pc_d    = 8'd0;
          instr_d = rd_data;
          vld_d   = 1'b1;
          cyc_d   = 32'd0;
        end else if ((state_q == S_IDLE) && ld_valid && !start && !full) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (illegal) begin
            state_d = S_HALT;
            vld_d   = 1'b0;
          end else if (cyc_q + 32'd1 == 32'(MAX_CYCLES)) begin
            state_d = S_DONE;
            vld_d   = 1'b0;
            cyc_d   = cyc_q + 32'd1;
          end else begin
            cyc_d   = cyc_q + 32'd1;
            pc_d    = pc_inc;
            instr_d = rd_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
      vld_q   <= 1'b0;
      pc_q    <= 8'd0;
      cnt_q   <= 9'd0;
      cyc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  assign ld_full        = full;
  assign instruction    = instr_q;
  assign instr_valid    = vld_q;
  assign pc             = pc_q;
  assign instr_count    = cnt_q;
  assign cycle_count    = cyc_q;
  assign done           = (state_q == S_DONE);
  assign halted_illegal = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=256, MAX_CYCLES=5); inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_full;
  logic        start;
  logic        instr_ready;
  logic        illegal;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [8:0]  instr_count;
  logic [31:0] cycle_count;
  logic        done;
  logic        halted_illegal;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.DEPTH(256), .MAX_CYCLES(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_full        (ld_full),
    .start          (start),
    .instr_ready    (instr_ready),
    .illegal        (illegal),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .instr_count    (instr_count),
    .cycle_count    (cycle_count),
    .done           (done),
    .halted_illegal (halted_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    ld_valid = 1'b0; start = 1'b0; instr_ready = 1'b0; illegal = 1'b0; ld_data = 32'd0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] w);
    ld_valid = 1'b1;
    ld_data  = w;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b0; start = 1'b0; instr_ready = 1'b0; illegal = 1'b0; ld_data = 32'd0;
    #3;
    checks++;
    if ({instruction, instr_valid, pc, instr_count, cycle_count, done, halted_illegal, ld_full} !== 85'd0) begin
      errors++;
      $display("FAIL reset_outputs: got instr=%h vld=%b pc=%0d cnt=%0d cyc=%0d done=%b halt=%b full=%b, expected all zero",
               instruction, instr_valid, pc, instr_count, cycle_count, done, halted_illegal, ld_full);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] w [4];
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = 32'hA000_0000 + 32'(i);
      load(w[i]);
    end
    checks++;
    if (instr_count !== 9'd4) begin
      errors++; $display("FAIL stream_count: got %0d expected 4", instr_count);
    end
    start_pulse();
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      k = i % 4;
      checks++;
      if (instruction !== w[k] || pc !== 8'(k) || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_step%0d: got instr=%h pc=%0d vld=%b expected instr=%h pc=%0d vld=1",
                 i, instruction, pc, instr_valid, w[k], k);
      end
    end
    instr_ready = 1'b0;
    checks++;
    if (cycle_count !== 32'd4) begin
      errors++; $display("FAIL stream_cycles: got %0d expected 4", cycle_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w [3];
    logic        rdy_pat [4];
    logic [7:0]  exp_pc [4];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = 32'hB000_0010 + 32'(i);
      load(w[i]);
    end
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_pc  = '{8'd1, 8'd1, 8'd1, 8'd2};
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      instr_ready = rdy_pat[i];
      illegal     = (i == 2);
      tick();
      checks++;
      if (pc !== exp_pc[i] || instruction !== w[exp_pc[i]] || instr_valid !== 1'b1 || halted_illegal !== 1'b0) begin
        errors++;
        $display("FAIL stall_step%0d: got pc=%0d instr=%h vld=%b halt=%b expected pc=%0d instr=%h vld=1 halt=0",
                 i, pc, instruction, instr_valid, halted_illegal, exp_pc[i], w[exp_pc[i]]);
      end
    end
    illegal = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (cycle_count !== 32'd2) begin
      errors++; $display("FAIL stall_cycles: got %0d expected 2", cycle_count);
    end
    start_pulse();
    checks++;
    if (pc !== 8'd2 || instruction !== w[2] || cycle_count !== 32'd2) begin
      errors++;
      $display("FAIL start_in_run: got pc=%0d instr=%h cyc=%0d expected pc=2 instr=%h cyc=2",
               pc, instruction, cycle_count, w[2]);
    end
  endtask

  task automatic test_max_cycles();
    do_reset();
    load(32'hC000_0000);
    load(32'hC000_0001);
    start_pulse();
    instr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (pc !== 8'(i % 2) || done !== 1'b0) begin
        errors++; $display("FAIL max_step%0d: got pc=%0d done=%b expected pc=%0d done=0", i, pc, done, i % 2);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || instr_valid !== 1'b0 || cycle_count !== 32'd5 || pc !== 8'd0) begin
      errors++;
      $display("FAIL max_done: got done=%b vld=%b cyc=%0d pc=%0d expected done=1 vld=0 cyc=5 pc=0",
               done, instr_valid, cycle_count, pc);
    end
    tick();
    checks++;
    if (done !== 1'b1 || cycle_count !== 32'd5) begin
      errors++; $display("FAIL max_hold: got done=%b cyc=%0d expected done=1 cyc=5", done, cycle_count);
    end
    instr_ready = 1'b0;
    start_pulse();
    checks++;
    if (done !== 1'b0 || instr_valid !== 1'b1 || pc !== 8'd0 || cycle_count !== 32'd0 || instruction !== 32'hC000_0000) begin
      errors++;
      $display("FAIL max_restart: got done=%b vld=%b pc=%0d cyc=%0d instr=%h expected done=0 vld=1 pc=0 cyc=0 instr=c0000000",
               done, instr_valid, pc, cycle_count, instruction);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 4; i++) load(32'hD000_0000 + 32'(i));
    start_pulse();
    instr_ready = 1'b1;
    tick();
    tick();
    illegal = 1'b1;
    tick();
    illegal = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (halted_illegal !== 1'b1 || pc !== 8'd2 || cycle_count !== 32'd2 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_halt: got halt=%b pc=%0d cyc=%0d vld=%b expected halt=1 pc=2 cyc=2 vld=0",
               halted_illegal, pc, cycle_count, instr_valid);
    end
    start_pulse();
    checks++;
    if (halted_illegal !== 1'b0 || instr_valid !== 1'b1 || pc !== 8'd0 || instruction !== 32'hD000_0000) begin
      errors++;
      $display("FAIL illegal_restart: got halt=%b vld=%b pc=%0d instr=%h expected halt=0 vld=1 pc=0 instr=d0000000",
               halted_illegal, instr_valid, pc, instruction);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    illegal = 1'b1;
    tick();
    illegal = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (halted_illegal !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd4 || pc !== 8'd0) begin
      errors++;
      $display("FAIL illegal_over_max: got halt=%b done=%b cyc=%0d pc=%0d expected halt=1 done=0 cyc=4 pc=0",
               halted_illegal, done, cycle_count, pc);
    end
  endtask

  task automatic test_start_with_load();
    do_reset();
    load(32'hE000_0000);
    ld_valid = 1'b1;
    ld_data  = 32'hE000_0001;
    start    = 1'b1;
    tick();
    ld_valid = 1'b0;
    start    = 1'b0;
    checks++;
    if (instr_count !== 9'd1 || instr_valid !== 1'b1 || instruction !== 32'hE000_0000) begin
      errors++;
      $display("FAIL start_wins: got cnt=%0d vld=%b instr=%h expected cnt=1 vld=1 instr=e0000000",
               instr_count, instr_valid, instruction);
    end
  endtask

  task automatic test_full();
    do_reset();
    start_pulse();
    checks++;
    if (instr_valid !== 1'b0 || done !== 1'b0 || halted_illegal !== 1'b0 || instr_count !== 9'd0) begin
      errors++;
      $display("FAIL empty_start: got vld=%b done=%b halt=%b cnt=%0d expected all 0",
               instr_valid, done, halted_illegal, instr_count);
    end
    for (int i = 0; i < 256; i++) begin
      load(32'h5A00_0000 + 32'(i));
      if (i == 254) begin
        checks++;
        if (ld_full !== 1'b0 || instr_count !== 9'd255) begin
          errors++; $display("FAIL full_255: got full=%b cnt=%0d expected full=0 cnt=255", ld_full, instr_count);
        end
      end
    end
    checks++;
    if (ld_full !== 1'b1 || instr_count !== 9'd256) begin
      errors++; $display("FAIL full_256: got full=%b cnt=%0d expected full=1 cnt=256", ld_full, instr_count);
    end
    load(32'hDEAD_BEEF);
    checks++;
    if (ld_full !== 1'b1 || instr_count !== 9'd256) begin
      errors++; $display("FAIL full_drop: got full=%b cnt=%0d expected full=1 cnt=256", ld_full, instr_count);
    end
    start_pulse();
    checks++;
    if (instruction !== 32'h5A00_0000 || pc !== 8'd0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_word0: got instr=%h pc=%0d vld=%b expected instr=5a000000 pc=0 vld=1",
               instruction, pc, instr_valid);
    end
  endtask

  task automatic test_rst_mid_run();
    do_reset();
    for (int i = 0; i < 4; i++) load(32'hF000_0000 + 32'(i));
    start_pulse();
    instr_ready = 1'b1;
    ld_valid    = 1'b1;
    ld_data     = 32'h1234_5678;
    tick();
    tick();
    tick();
    ld_valid = 1'b0;
    checks++;
    if (pc !== 8'd3 || instr_count !== 9'd4 || instruction !== 32'hF000_0003) begin
      errors++;
      $display("FAIL run_ignores_load: got pc=%0d cnt=%0d instr=%h expected pc=3 cnt=4 instr=f0000003",
               pc, instr_count, instruction);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({instruction, instr_valid, pc, instr_count, cycle_count, done, halted_illegal, ld_full} !== 85'd0) begin
      errors++;
      $display("FAIL rst_mid_run: got instr=%h vld=%b pc=%0d cnt=%0d cyc=%0d done=%b halt=%b full=%b, expected all zero",
               instruction, instr_valid, pc, instr_count, cycle_count, done, halted_illegal, ld_full);
    end
    #2;
    rst = 1'b0;
    instr_ready = 1'b0;
    tick();
    start_pulse();
    checks++;
    if (instr_valid !== 1'b0 || instr_count !== 9'd0) begin
      errors++; $display("FAIL rst_then_start: got vld=%b cnt=%0d expected vld=0 cnt=0", instr_valid, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_max_cycles();
    test_illegal();
    test_start_with_load();
    test_full();
    test_rst_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 256, meaning instruction memory entries.
REQ-002 Parameter MAX_CYCLES, default 1000, meaning accepted-instruction limit before DONE.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ld_valid  input  1  load strobe, appends ld_data to memory.
REQ-007 ld_data  input  32  instruction word to load.
REQ-008 ld_full  output  1  high when instr_count == DEPTH.
REQ-009 start  input  1  single-cycle pulse: begin or restart streaming.
REQ-010 instr_ready  input  1  core accepts current instruction.
REQ-011 illegal  input  1  core flags the presented instruction illegal.
REQ-012 instruction  output  32  registered instruction word to core.
REQ-013 instr_valid  output  1  instruction holds a valid word.
REQ-014 pc  output  8  memory index of presented word.
REQ-015 instr_count  output  9  number of loaded words, 0..DEPTH.
REQ-016 cycle_count  output  32  handshakes completed since last start.
REQ-017 done  output  1  high in DONE state.
REQ-018 halted_illegal  output  1  high in HALT state.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DONE, HALT.
REQ-020 IDLE: ld_valid with !ld_full writes mem[instr_count], increments instr_count; ld_valid when full is dropped, no count change.
REQ-021 ld_valid outside IDLE SHALL be ignored.
REQ-022 start in IDLE/DONE/HALT with instr_count==0 SHALL be ignored, state unchanged.
REQ-023 start with instr_count>0: next cycle RUN, pc=0, instruction=mem[0], instr_valid=1, cycle_count=0.
REQ-024 Simultaneous start and ld_valid in IDLE: start wins, load dropped, start evaluated against old instr_count.
REQ-025 Handshake = instr_valid & instr_ready in RUN; instruction and pc SHALL stay stable while instr_valid & !instr_ready.
REQ-026 On handshake with !illegal: cycle_count+1; pc wraps to 0 when pc+1==instr_count, else pc+1; instruction=mem[next pc] next cycle (zero-bubble streaming).
REQ-027 Handshake where cycle_count+1 == MAX_CYCLES: next cycle DONE, instr_valid=0, cycle_count=MAX_CYCLES, pc unchanged.
REQ-028 Handshake with illegal=1: next cycle HALT, instr_valid=0, pc holds offending index, cycle_count not incremented; illegal takes priority over MAX_CYCLES.
REQ-029 illegal without handshake SHALL be ignored.
REQ-030 start in RUN SHALL be ignored.
REQ-031 Memory contents SHALL persist across DONE/HALT/restart; only instr_count reset clears the program.

Reset
REQ-032 rst asserted: state IDLE, instruction=0, instr_valid=0, pc=0, instr_count=0, cycle_count=0, done=0, halted_illegal=0, ld_full=0, asynchronously.
REQ-033 rst mid-RUN SHALL drop instr_valid immediately; memory array is not reset.

Structure
REQ-034 qtpa_pkg SHALL hold fetch_state_t enum and FETCH_DEPTH, FETCH_MAX_CYCLES defaults.
REQ-035 One sub-module fetch_imem: DEPTH x 32 array, one write port, one combinational read port, no reset.

Verification
REQ-036 Load 4 words A0..A3, start, ready=1 -> instruction sequence A0,A1,A2,A3,A0 on consecutive cycles, pc 0,1,2,3,0.
REQ-037 Load 3 words, start, ready toggles 1,0,0,1 -> word held stable during ready=0, cycle_count=2 after four cycles.
REQ-038 Load 2 words, MAX_CYCLES=5, ready=1 -> done=1 after 5th handshake, instr_valid=0, cycle_count=5, pc=0.
REQ-039 Load 4 words, illegal=1 with handshake at pc=2 -> halted_illegal=1, pc=2, cycle_count=2; start -> RUN from pc=0.
REQ-040 Load 256 words then 1 more -> ld_full=1, instr_count=256, 257th dropped; start with empty memory -> stays IDLE.
REQ-041 rst pulse mid-RUN at pc=3 -> all outputs zero; start -> ignored (instr_count=0).
